// File: rtl/mlp_load_pkg.sv
// mlp_load_pkg
// Shared types and constants for the MLP load sequencer and its lane packer.
//   load_state_e     : sequencer FSM state encoding
//   LOAD_TYPE_INPUT  : load_type_o value for an input-row beat
//   LOAD_TYPE_WEIGHT : load_type_o value for a weight beat
//   beats_per_row()  : number of packed beats that carry one matrix row
package mlp_load_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IN_ROW = 2'd1,
      W_ROW  = 2'd2,
      FINISH = 2'd3
   } load_state_e;

   localparam logic LOAD_TYPE_INPUT  = 1'b1;
   localparam logic LOAD_TYPE_WEIGHT = 1'b0;

   function automatic int beats_per_row(input int dim, input int lanes);
      return dim / lanes;
   endfunction

endpackage

// File: rtl/mlp_lane_packer.sv
// mlp_lane_packer
// Packs LANES consecutive stream elements into one load beat and owns the
// single-entry output slot that presents the beat to the accelerator.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_enable         : sequencer is in a row-loading state and may accept data
//   i_s_valid        : upstream element valid
//   o_s_ready        : element accepted when i_s_valid && o_s_ready
//   i_s_data         : upstream element
//   i_load_ready     : accelerator takes the beat held in the output slot
//   o_load_en        : output slot holds a valid beat
//   o_load_payload   : packed beat, lane k in bits [k*DATA_W +: DATA_W]
//   o_beat_load      : final lane accepted this cycle; a new beat enters the slot
module mlp_lane_packer #(
   parameter int DATA_W = 16,
   parameter int LANES  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_enable,
   input  logic                    i_s_valid,
   output logic                    o_s_ready,
   input  logic [DATA_W-1:0]       i_s_data,
   input  logic                    i_load_ready,
   output logic                    o_load_en,
   output logic [LANES*DATA_W-1:0] o_load_payload,
   output logic                    o_beat_load
);

   localparam int              LC_W      = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LC_W-1:0] LAST_LANE = LC_W'(LANES - 1);

   logic [LC_W-1:0]         r_lane;
   logic [LANES*DATA_W-1:0] r_pack;
   logic [LANES*DATA_W-1:0] r_payload;
   logic                    r_load_en;
   logic [LANES*DATA_W-1:0] w_payload_nxt;
   logic                    w_final_lane;
   logic                    w_accept;

   // Only the element that completes a beat needs a free output slot; the
   // slot counts as free when its current beat retires in this same cycle.
   assign w_final_lane   = (r_lane == LAST_LANE);
   assign o_s_ready      = i_enable && (!w_final_lane || !r_load_en || i_load_ready);
   assign w_accept       = i_s_valid && o_s_ready;
   assign o_beat_load    = w_accept && w_final_lane;
   assign o_load_en      = r_load_en;
   assign o_load_payload = r_payload;

   // Full beat = earlier lanes from the pack register plus the incoming element.
   always_comb begin
      w_payload_nxt = r_pack;
      w_payload_nxt[(LANES-1)*DATA_W +: DATA_W] = i_s_data;
   end

   // Lane counter, pack register and output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane    <= '0;
         r_pack    <= '0;
         r_payload <= '0;
         r_load_en <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_final_lane) begin
               r_lane <= '0;
            end else begin
               r_lane <= r_lane + LC_W'(1);
               r_pack[r_lane*DATA_W +: DATA_W] <= i_s_data;
            end
         end
         if (o_beat_load) begin
            r_load_en <= 1'b1;
            r_payload <= w_payload_nxt;
         end else if (i_load_ready) begin
            r_load_en <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer
// Converts a flat element stream into the accelerator load protocol: packs
// LANES elements per beat and tags each beat with type, row, weight-beat and
// layer indices. Layer 0 interleaves an input row with a weight row; later
// layers stream weight rows only.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start_i, num_layers_i : begin a run of num_layers_i layers (sampled in IDLE)
//   busy_o, done_o        : run in progress / one-cycle end-of-run pulse
//   s_valid_i, s_ready_o, s_data_i       : upstream element stream
//   load_en_o, load_ready_i              : output beat handshake
//   load_payload_o, load_type_o          : packed beat and its type (1 = input)
//   input_load_number_o, layer_number_o, weight_number_o : beat indices
module mlp_load_sequencer
   import mlp_load_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIM    = 16,
   parameter int LANES  = 2,
   parameter int LAYERS = 8
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start_i,
   input  logic [$clog2(LAYERS+1)-1:0]              num_layers_i,
   output logic                                     busy_o,
   output logic                                     done_o,
   input  logic                                     s_valid_i,
   output logic                                     s_ready_o,
   input  logic [DATA_W-1:0]                        s_data_i,
   output logic                                     load_en_o,
   input  logic                                     load_ready_i,
   output logic [LANES*DATA_W-1:0]                  load_payload_o,
   output logic                                     load_type_o,
   output logic [$clog2(DIM)-1:0]                   input_load_number_o,
   output logic [$clog2(LAYERS)-1:0]                layer_number_o,
   output logic [$clog2(beats_per_row(DIM, LANES))-1:0] weight_number_o
);

   localparam int BEATS = beats_per_row(DIM, LANES);
   localparam int NL_W  = $clog2(LAYERS + 1);
   localparam int LY_W  = $clog2(LAYERS);
   localparam int RW_W  = $clog2(DIM);
   localparam int WN_W  = $clog2(BEATS);

   if ((DIM % LANES) != 0) begin : g_lanes_check
      $error("mlp_load_sequencer: DIM must be a multiple of LANES");
   end

   load_state_e     r_state, w_state_nxt;
   logic [RW_W-1:0] r_row, w_row_nxt;
   logic [WN_W-1:0] r_beat, w_beat_nxt;
   logic [LY_W-1:0] r_layer, w_layer_nxt;
   logic [NL_W-1:0] r_num_layers, w_num_layers_nxt;
   logic            r_drain, w_drain_nxt;
   logic            r_busy;
   logic            r_done;
   logic            r_type;
   logic [RW_W-1:0] r_row_o;
   logic [LY_W-1:0] r_layer_o;
   logic [WN_W-1:0] r_wn_o;
   logic            w_enable;
   logic            w_beat_load;
   logic            w_beat_last;
   logic            w_row_last;
   logic            w_layer_last;

   // Once the final beat of the run is loaded (r_drain) no more elements are taken.
   assign w_enable     = ((r_state == IN_ROW) || (r_state == W_ROW)) && !r_drain;
   assign w_beat_last  = (r_beat == WN_W'(BEATS - 1));
   assign w_row_last   = (r_row == RW_W'(DIM - 1));
   assign w_layer_last = ((NL_W'(r_layer) + NL_W'(1)) == r_num_layers);

   mlp_lane_packer #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_packer (
      .clk            (clk),
      .rst            (rst),
      .i_enable       (w_enable),
      .i_s_valid      (s_valid_i),
      .o_s_ready      (s_ready_o),
      .i_s_data       (s_data_i),
      .i_load_ready   (load_ready_i),
      .o_load_en      (load_en_o),
      .o_load_payload (load_payload_o),
      .o_beat_load    (w_beat_load)
   );

   // Next-state and index advance; indices move when a beat is loaded, not when it retires.
   always_comb begin
      w_state_nxt      = r_state;
      w_row_nxt        = r_row;
      w_beat_nxt       = r_beat;
      w_layer_nxt      = r_layer;
      w_num_layers_nxt = r_num_layers;
      w_drain_nxt      = r_drain;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               if (num_layers_i != NL_W'(0)) begin
                  w_num_layers_nxt = num_layers_i;
                  w_row_nxt        = '0;
                  w_beat_nxt       = '0;
                  w_layer_nxt      = '0;
                  w_drain_nxt      = 1'b0;
                  w_state_nxt      = IN_ROW;
               end else begin
                  w_state_nxt = FINISH;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         IN_ROW: begin
            if (w_beat_load) begin
               if (w_beat_last) begin
                  w_beat_nxt  = '0;
                  w_state_nxt = W_ROW;
               end else begin
                  w_beat_nxt = r_beat + WN_W'(1);
               end
            end else begin
               w_state_nxt = IN_ROW;
            end
         end
         W_ROW: begin
            if (r_drain) begin
               // Wait for the last beat of the run to leave the output slot.
               if (!load_en_o || load_ready_i) begin
                  w_drain_nxt = 1'b0;
                  w_state_nxt = FINISH;
               end else begin
                  w_state_nxt = W_ROW;
               end
            end else if (w_beat_load) begin
               if (w_beat_last) begin
                  w_beat_nxt = '0;
                  if (w_row_last) begin
                     w_row_nxt = '0;
                     if (w_layer_last) begin
                        w_drain_nxt = 1'b1;
                     end else begin
                        w_layer_nxt = r_layer + LY_W'(1);
                     end
                  end else begin
                     w_row_nxt = r_row + RW_W'(1);
                     // Only layer 0 interleaves input rows with weight rows.
                     w_state_nxt = (r_layer == LY_W'(0)) ? IN_ROW : W_ROW;
                  end
               end else begin
                  w_beat_nxt = r_beat + WN_W'(1);
               end
            end else begin
               w_state_nxt = W_ROW;
            end
         end
         FINISH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, counters, status flags and the index registers that travel with each beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_row        <= '0;
         r_beat       <= '0;
         r_layer      <= '0;
         r_num_layers <= '0;
         r_drain      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_type       <= 1'b0;
         r_row_o      <= '0;
         r_layer_o    <= '0;
         r_wn_o       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_row        <= w_row_nxt;
         r_beat       <= w_beat_nxt;
         r_layer      <= w_layer_nxt;
         r_num_layers <= w_num_layers_nxt;
         r_drain      <= w_drain_nxt;
         r_busy       <= (w_state_nxt == IN_ROW) || (w_state_nxt == W_ROW);
         r_done       <= (w_state_nxt == FINISH);
         if (w_beat_load) begin
            r_type    <= (r_state == IN_ROW) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
            r_row_o   <= r_row;
            r_layer_o <= r_layer;
            r_wn_o    <= (r_state == IN_ROW) ? '0 : r_beat;
         end
      end
   end

   assign busy_o              = r_busy;
   assign done_o              = r_done;
   assign load_type_o         = r_type;
   assign input_load_number_o = r_row_o;
   assign layer_number_o      = r_layer_o;
   assign weight_number_o     = r_wn_o;

endmodule
